// File: rtl/shift_count_reg.sv
// shift_count_reg: WIDTH-bit hold/shift/rotate/load/count register with
// asynchronous clear and preset, true/complement outputs and terminal count.
module shift_count_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so_r,
    output logic             so_l,
    output logic             tc
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_UP   = 3'b110;
    localparam logic [2:0] M_DN   = 3'b111;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             set_pre;
    logic             clr_any;

    // Preset only counts while clear is low, so a falling clear with preset
    // still high produces a rising set edge and re-forces PRE_VAL.
    assign set_pre = pre & ~clr;
    assign clr_any = clr | pre;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                M_HOLD: q_d = q_q;
                M_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                M_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                M_LOAD: q_d = d;
                M_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                M_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                M_UP:   q_d = q_q + 1'b1;
                M_DN:   q_d = q_q - 1'b1;
                default: q_d = q_q;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_q;

        if (PRE_VAL[i]) begin : g_set
            always_ff @(posedge clk or posedge clr or posedge set_pre) begin
                if (clr) begin
                    bit_q <= 1'b0;
                end else if (set_pre) begin
                    bit_q <= 1'b1;
                end else begin
                    bit_q <= q_d[i];
                end
            end
        end else begin : g_clr
            always_ff @(posedge clk or posedge clr_any) begin
                if (clr_any) begin
                    bit_q <= 1'b0;
                end else begin
                    bit_q <= q_d[i];
                end
            end
        end

        assign q_q[i] = bit_q;
    end

    assign q    = q_q;
    assign qb   = ~q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];
    assign tc   = ((mode == M_UP) && (&q_q)) || ((mode == M_DN) && ~(|q_q));

endmodule

// File: tb/tb_shift_count_reg.sv
// Scoreboard bench for shift_count_reg at WIDTH 8, 2 and 32, driven by
// directed scenarios and random stimulus against an arithmetic model.
module tb_shift_count_reg;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        pre = 1'b0;
    logic        en = 1'b0;
    logic        sin_r = 1'b0;
    logic        sin_l = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] d32 = 32'd0;

    logic [7:0]  q8, qb8;
    logic [1:0]  q2, qb2;
    logic [31:0] q32, qb32;
    logic        sr8, sl8, tc8, sr2, sl2, tc2, sr32, sl32, tc32;

    always #5 clk = ~clk;

    shift_count_reg #(.WIDTH(8)) u8 (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode),
        .d(d32[7:0]), .sin_r(sin_r), .sin_l(sin_l),
        .q(q8), .qb(qb8), .so_r(sr8), .so_l(sl8), .tc(tc8)
    );

    shift_count_reg #(.WIDTH(2)) u2 (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode),
        .d(d32[1:0]), .sin_r(sin_r), .sin_l(sin_l),
        .q(q2), .qb(qb2), .so_r(sr2), .so_l(sl2), .tc(tc2)
    );

    shift_count_reg #(.WIDTH(32), .PRE_VAL(32'h1234_5678)) u32 (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode),
        .d(d32), .sin_r(sin_r), .sin_l(sin_l),
        .q(q32), .qb(qb32), .so_r(sr32), .so_l(sl32), .tc(tc32)
    );

    typedef struct {
        int          inst;
        logic [31:0] q;
        logic        tc;
    } exp_t;

    exp_t            sb[$];
    event            chk_ev;
    int              tests = 0;
    int              fails = 0;
    int              W[3] = '{8, 2, 32};
    longint unsigned PV[3] = '{64'hFF, 64'h3, 64'h1234_5678};
    longint unsigned mv[3] = '{64'd0, 64'd0, 64'd0};

    function automatic longint unsigned mask(int i);
        return (64'd1 << W[i]) - 64'd1;
    endfunction

    function automatic logic tcm(int i);
        return ((mode == 3'd6) && (mv[i] == mask(i))) ||
               ((mode == 3'd7) && (mv[i] == 64'd0));
    endfunction

    function automatic longint unsigned nxt(longint unsigned v, int i);
        longint unsigned mk = mask(i);
        int              w = W[i];
        if (!en) return v;
        case (mode)
            3'd1: return (v >> 1) | ({63'd0, sin_r} << (w - 1));
            3'd2: return ((v << 1) | {63'd0, sin_l}) & mk;
            3'd3: return {32'd0, d32} & mk;
            3'd4: return (v >> 1) | ((v & 64'd1) << (w - 1));
            3'd5: return ((v << 1) | (v >> (w - 1))) & mk;
            3'd6: return (v + 64'd1) & mk;
            3'd7: return (v - 64'd1) & mk;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!clr && !pre) begin
            for (int i = 0; i < 3; i++) mv[i] = nxt(mv[i], i);
        end
    end

    task automatic push_c(int i, logic [31:0] v, logic t);
        exp_t e;
        e.inst = i;
        e.q = v;
        e.tc = t;
        sb.push_back(e);
    endtask

    task automatic push_all(int x8, int t8);
        for (int i = 0; i < 3; i++) push_c(i, 32'(mv[i]), tcm(i));
        if (x8 >= 0) push_c(0, x8[31:0], t8[0]);
    endtask

    task automatic fire();
        -> chk_ev;
        #2;
    endtask

    task automatic drive(logic e, logic [2:0] m, logic sr, logic sl,
                         logic [31:0] dv, int x8 = -1, int t8 = -1);
        @(negedge clk);
        en = e; mode = m; sin_r = sr; sin_l = sl; d32 = dv;
        #1;
        push_all(x8, t8);
        fire();
    endtask

    task automatic tick(int x8 = -1, int t8 = -1);
        @(posedge clk);
        #1;
        push_all(x8, t8);
        fire();
    endtask

    task automatic set_async(logic c, logic p, int x8 = -1, int t8 = -1);
        @(negedge clk);
        #1;
        clr = c;
        pre = p;
        for (int i = 0; i < 3; i++) begin
            if (c) mv[i] = 64'd0;
            else if (p) mv[i] = PV[i];
        end
        push_all(x8, t8);
        fire();
    endtask

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[w%0d] got %h expected %h at %0t",
                     nm, W[i], act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] aq, aqb, mk;
        logic        asr, asl, atc;
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.inst)
                    0: begin
                        aq = 32'(q8); aqb = 32'(qb8);
                        asr = sr8; asl = sl8; atc = tc8;
                    end
                    1: begin
                        aq = 32'(q2); aqb = 32'(qb2);
                        asr = sr2; asl = sl2; atc = tc2;
                    end
                    default: begin
                        aq = q32; aqb = qb32;
                        asr = sr32; asl = sl32; atc = tc32;
                    end
                endcase
                mk = 32'(mask(e.inst));
                chk("q", e.inst, aq, e.q);
                chk("qb", e.inst, aqb, ~e.q & mk);
                chk("so_r", e.inst, 32'(asr), 32'(e.q[0]));
                chk("so_l", e.inst, 32'(asl), 32'(e.q[W[e.inst]-1]));
                chk("tc", e.inst, 32'(atc), 32'(e.tc));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        clr = 1'b1;
        #1;
        push_all(0, 0);
        fire();

        // async priority
        set_async(0, 0, 'h00, 0);
        drive(1, 3'd3, 0, 0, 32'hA5);
        tick('hA5, 0);
        drive(1, 3'd0, 0, 0, 32'h0);
        set_async(0, 1, 'hFF, 0);
        push_c(2, 32'h1234_5678, 1'b0);
        fire();
        set_async(1, 1, 'h00, 0);
        set_async(0, 1, 'hFF, 0);
        set_async(0, 0, 'hFF, 0);
        tick('hFF, 0);

        // shift
        set_async(1, 0, 'h00, 0);
        set_async(0, 0, 'h00, 0);
        drive(1, 3'd1, 1, 0, 32'h0);
        tick('h80, 0);
        tick('hC0, 0);
        tick('hE0, 0);
        drive(1, 3'd2, 0, 0, 32'h0);
        tick('hC0, 0);
        tick('h80, 0);

        // rotate
        drive(1, 3'd3, 0, 0, 32'h81);
        tick('h81, 0);
        drive(1, 3'd4, 0, 0, 32'h0);
        tick('hC0, 0);
        drive(1, 3'd5, 0, 0, 32'h0);
        tick('h81, 0);
        tick('h03, 0);

        // count wrap
        drive(1, 3'd3, 0, 0, 32'hFE);
        tick('hFE, 0);
        drive(1, 3'd6, 0, 0, 32'h0, 'hFE, 0);
        tick('hFF, 1);
        tick('h00, 0);
        drive(1, 3'd7, 0, 0, 32'h0, 'h00, 1);
        tick('hFF, 0);

        // enable gating and mid-cycle mode change
        drive(1, 3'd3, 0, 0, 32'h3C);
        tick('h3C, 0);
        for (int m = 0; m < 8; m++) begin
            drive(0, 3'(m), 1, 1, 32'hFFFF_FFFF);
            tick('h3C, 0);
        end
        @(negedge clk);
        en = 1'b1; mode = 3'd3; d32 = 32'h0;
        #2;
        mode = 3'd6;
        tick('h3D, 0);

        // all-ones count-up wrap at every width
        drive(1, 3'd3, 0, 0, 32'hFFFF_FFFF);
        tick('hFF, 0);
        drive(1, 3'd6, 0, 0, 32'h0, 'hFF, 1);
        tick('h00, 0);
        push_c(1, 32'h0, 1'b0);
        push_c(2, 32'h0, 1'b0);
        fire();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                set_async(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                set_async(0, 0);
            end
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), $urandom);
            tick();
        end

        #20;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
